// File: rtl/secuenciador_instrucciones.sv
// Instruction sequencer: holds a short program and plays it out under valid/ready.
// Optional single-step mode (PASO input) is enabled by defining SECUENCIADOR_PASO_EN.
module secuenciador_instrucciones #(
   parameter int PROF = 32,
   parameter int AW   = 5,
   parameter int IW   = 20
) (
   input  logic          CLK,
   input  logic          RST_N,
`ifdef SECUENCIADOR_PASO_EN
   input  logic          PASO,
`endif
   input  logic          CARGA_WE,
   input  logic [AW-1:0] CARGA_DIR,
   input  logic [IW-1:0] CARGA_DATO,
   input  logic [AW:0]   LONGITUD,
   input  logic          BUCLE,
   input  logic          INICIO,
   input  logic          DETENER,
   output logic [IW-1:0] INSTRUCCION,
   output logic          VALIDO,
   input  logic          LISTO,
   output logic          OCUPADO,
   output logic          FIN,
   output logic [AW-1:0] PC
);

   localparam logic [1:0] ST_REPOSO = 2'd0;
   localparam logic [1:0] ST_LEER   = 2'd1;
   localparam logic [1:0] ST_EMITIR = 2'd2;
   localparam logic [1:0] ST_FIN    = 2'd3;

   localparam logic [AW:0] PROF_L = (AW+1)'(PROF);
   localparam logic [AW:0] UNO    = (AW+1)'(1);

   logic [IW-1:0] mem [PROF];

   logic [1:0]    state_r;
   logic [IW-1:0] instr_r;
   logic          valido_r;
   logic          ocupado_r;
   logic          fin_r;
   logic [AW-1:0] pc_r;
   logic [AW-1:0] pos_r;
   logic [AW:0]   long_r;
   logic          bucle_r;
   logic          stop_r;

   logic          ultimo_s;
   logic [AW-1:0] siguiente_s;
   logic [AW:0]   long_clamp_s;
   logic          paso_s;
   logic          terminar_s;

   assign INSTRUCCION = instr_r;
   assign VALIDO      = valido_r;
   assign OCUPADO     = ocupado_r;
   assign FIN         = fin_r;
   assign PC          = pc_r;

   // Next-address and termination decisions for the word currently held.
   always_comb begin
      ultimo_s     = ({1'b0, pos_r} == (long_r - UNO));
      terminar_s   = DETENER || stop_r || (ultimo_s && !bucle_r);
      long_clamp_s = LONGITUD;
      if (LONGITUD > PROF_L) begin
         long_clamp_s = PROF_L;
      end else begin
         long_clamp_s = LONGITUD;
      end
      if (ultimo_s) begin
         siguiente_s = {AW{1'b0}};
      end else begin
         siguiente_s = pos_r + AW'(1);
      end
`ifdef SECUENCIADOR_PASO_EN
      paso_s = PASO;
`else
      paso_s = 1'b1;
`endif
   end

   // Program store; writes only land while the sequencer is idle.
   always_ff @(posedge CLK) begin
      if (CARGA_WE && (state_r == ST_REPOSO)) begin
         mem[CARGA_DIR] <= CARGA_DATO;
      end
   end

   // Control FSM with registered outputs; the output word is the synchronous read register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r   <= ST_REPOSO;
         instr_r   <= {IW{1'b0}};
         valido_r  <= 1'b0;
         ocupado_r <= 1'b0;
         fin_r     <= 1'b0;
         pc_r      <= {AW{1'b0}};
         pos_r     <= {AW{1'b0}};
         long_r    <= {(AW+1){1'b0}};
         bucle_r   <= 1'b0;
         stop_r    <= 1'b0;
      end else begin
         fin_r <= 1'b0;
         case (state_r)
            ST_REPOSO: begin
               if (INICIO) begin
                  if (LONGITUD == {(AW+1){1'b0}}) begin
                     state_r <= ST_FIN;
                     fin_r   <= 1'b1;
                  end else begin
                     state_r   <= ST_LEER;
                     long_r    <= long_clamp_s;
                     bucle_r   <= BUCLE;
                     pos_r     <= {AW{1'b0}};
                     pc_r      <= {AW{1'b0}};
                     ocupado_r <= 1'b1;
                     stop_r    <= 1'b0;
                  end
               end
            end
            ST_LEER: begin
               if (DETENER) begin
                  state_r   <= ST_FIN;
                  fin_r     <= 1'b1;
                  ocupado_r <= 1'b0;
                  pc_r      <= {AW{1'b0}};
               end else begin
                  state_r <= ST_EMITIR;
`ifdef SECUENCIADOR_PASO_EN
                  valido_r <= 1'b0;
`else
                  instr_r  <= mem[{AW{1'b0}}];
                  valido_r <= 1'b1;
                  pc_r     <= {AW{1'b0}};
`endif
               end
            end
            ST_EMITIR: begin
               if (valido_r) begin
                  if (LISTO) begin
                     if (terminar_s) begin
                        state_r   <= ST_FIN;
                        fin_r     <= 1'b1;
                        valido_r  <= 1'b0;
                        ocupado_r <= 1'b0;
                        pc_r      <= {AW{1'b0}};
                        stop_r    <= 1'b0;
                     end else begin
                        pos_r <= siguiente_s;
`ifdef SECUENCIADOR_PASO_EN
                        valido_r <= 1'b0;
                        pc_r     <= {AW{1'b0}};
`else
                        instr_r  <= mem[siguiente_s];
                        pc_r     <= siguiente_s;
`endif
                     end
                  end else if (DETENER) begin
                     stop_r <= 1'b1;
                  end else begin
                     stop_r <= stop_r;
                  end
               end else begin
                  // Waiting for a step pulse; a stop here ends without presenting a word.
                  if (DETENER || stop_r) begin
                     state_r   <= ST_FIN;
                     fin_r     <= 1'b1;
                     ocupado_r <= 1'b0;
                     pc_r      <= {AW{1'b0}};
                     stop_r    <= 1'b0;
                  end else if (paso_s) begin
                     instr_r  <= mem[pos_r];
                     pc_r     <= pos_r;
                     valido_r <= 1'b1;
                  end else begin
                     valido_r <= 1'b0;
                  end
               end
            end
            ST_FIN: begin
               state_r <= ST_REPOSO;
            end
            default: begin
               state_r   <= ST_REPOSO;
               valido_r  <= 1'b0;
               ocupado_r <= 1'b0;
               pc_r      <= {AW{1'b0}};
               stop_r    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_secuenciador_instrucciones.sv
// Directed self-checking bench for secuenciador_instrucciones (default build).
module tb_secuenciador_instrucciones;

   logic        CLK;
   logic        RST_N;
   logic        paso;
   logic        CARGA_WE;
   logic [4:0]  CARGA_DIR;
   logic [19:0] CARGA_DATO;
   logic [5:0]  LONGITUD;
   logic        BUCLE;
   logic        INICIO;
   logic        DETENER;
   logic [19:0] INSTRUCCION;
   logic        VALIDO;
   logic        LISTO;
   logic        OCUPADO;
   logic        FIN;
   logic [4:0]  PC;

   int errors = 0;
   int checks = 0;
   logic [19:0] prog [32];

   secuenciador_instrucciones #(.PROF(32), .AW(5), .IW(20)) dut (
      .CLK(CLK),
      .RST_N(RST_N),
`ifdef SECUENCIADOR_PASO_EN
      .PASO(paso),
`endif
      .CARGA_WE(CARGA_WE),
      .CARGA_DIR(CARGA_DIR),
      .CARGA_DATO(CARGA_DATO),
      .LONGITUD(LONGITUD),
      .BUCLE(BUCLE),
      .INICIO(INICIO),
      .DETENER(DETENER),
      .INSTRUCCION(INSTRUCCION),
      .VALIDO(VALIDO),
      .LISTO(LISTO),
      .OCUPADO(OCUPADO),
      .FIN(FIN),
      .PC(PC)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic word(input string tag, input logic [19:0] w, input logic [4:0] p);
      chk({tag, "_valido"}, 32'(VALIDO), 32'd1);
      chk({tag, "_instr"}, 32'(INSTRUCCION), 32'(w));
      chk({tag, "_pc"}, 32'(PC), 32'(p));
   endtask

   task automatic load(input logic [4:0] a, input logic [19:0] d);
      CARGA_WE = 1'b1;
      CARGA_DIR = a;
      CARGA_DATO = d;
      tick();
      CARGA_WE = 1'b0;
   endtask

   task automatic run_basic(input string tag);
      LONGITUD = 6'd3;
      BUCLE = 1'b0;
      LISTO = 1'b1;
      INICIO = 1'b1;
      tick();
      INICIO = 1'b0;
      chk({tag, "_c1_ocupado"}, 32'(OCUPADO), 32'd1);
      chk({tag, "_c1_valido"}, 32'(VALIDO), 32'd0);
      tick();
      word({tag, "_c2"}, 20'h80000, 5'd0);
      tick();
      word({tag, "_c3"}, 20'h40421, 5'd1);
      tick();
      word({tag, "_c4"}, 20'h0A5E3, 5'd2);
      tick();
      chk({tag, "_c5_fin"}, 32'(FIN), 32'd1);
      chk({tag, "_c5_valido"}, 32'(VALIDO), 32'd0);
      chk({tag, "_c5_ocupado"}, 32'(OCUPADO), 32'd0);
      tick();
      chk({tag, "_c6_fin"}, 32'(FIN), 32'd0);
   endtask

   initial begin
      int n;
      int bad;
      logic fin_seen;

      RST_N = 1'b0;
      paso = 1'b0;
      CARGA_WE = 1'b0;
      CARGA_DIR = 5'd0;
      CARGA_DATO = 20'h00000;
      LONGITUD = 6'd0;
      BUCLE = 1'b0;
      INICIO = 1'b0;
      DETENER = 1'b0;
      LISTO = 1'b0;
      #3;
      chk("rst_valido", 32'(VALIDO), 32'd0);
      chk("rst_ocupado", 32'(OCUPADO), 32'd0);
      chk("rst_fin", 32'(FIN), 32'd0);
      chk("rst_pc", 32'(PC), 32'd0);
      chk("rst_instr", 32'(INSTRUCCION), 32'd0);
      #10;
      RST_N = 1'b1;
      tick();

      prog[0] = 20'h80000;
      prog[1] = 20'h40421;
      prog[2] = 20'h0A5E3;
      for (int i = 3; i < 32; i++) prog[i] = {5'(i), 15'h5A5A};
      for (int i = 0; i < 32; i++) load(5'(i), prog[i]);

      // Single pass, LISTO always high.
      run_basic("basic");

      // Back-pressure on word 1.
      LONGITUD = 6'd3;
      BUCLE = 1'b0;
      LISTO = 1'b1;
      INICIO = 1'b1;
      tick();
      INICIO = 1'b0;
      tick();
      word("stall_w0", 20'h80000, 5'd0);
      tick();
      word("stall_w1", 20'h40421, 5'd1);
      LISTO = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         word("stall_hold", 20'h40421, 5'd1);
      end
      LISTO = 1'b1;
      tick();
      word("stall_w2", 20'h0A5E3, 5'd2);
      tick();
      chk("stall_fin", 32'(FIN), 32'd1);
      tick();

      // Loop of two words, then stop while word 1 is presented.
      LONGITUD = 6'd2;
      BUCLE = 1'b1;
      LISTO = 1'b1;
      INICIO = 1'b1;
      tick();
      INICIO = 1'b0;
      BUCLE = 1'b0;
      tick();
      word("loop_a0", 20'h80000, 5'd0);
      tick();
      word("loop_a1", 20'h40421, 5'd1);
      tick();
      word("loop_b0", 20'h80000, 5'd0);
      tick();
      word("loop_b1", 20'h40421, 5'd1);
      DETENER = 1'b1;
      tick();
      DETENER = 1'b0;
      chk("loop_stop_fin", 32'(FIN), 32'd1);
      chk("loop_stop_valido", 32'(VALIDO), 32'd0);
      chk("loop_stop_pc", 32'(PC), 32'd0);
      tick();

      // Zero length ends immediately.
      LONGITUD = 6'd0;
      INICIO = 1'b1;
      tick();
      INICIO = 1'b0;
      chk("len0_fin", 32'(FIN), 32'd1);
      chk("len0_valido", 32'(VALIDO), 32'd0);
      chk("len0_ocupado", 32'(OCUPADO), 32'd0);
      tick();
      chk("len0_fin_end", 32'(FIN), 32'd0);
      chk("len0_valido_end", 32'(VALIDO), 32'd0);

      // Oversized length clamps to the full 32-word program.
      LONGITUD = 6'd40;
      BUCLE = 1'b0;
      LISTO = 1'b1;
      INICIO = 1'b1;
      tick();
      INICIO = 1'b0;
      n = 0;
      bad = 0;
      fin_seen = 1'b0;
      for (int c = 0; c < 50 && !fin_seen; c++) begin
         tick();
         if (VALIDO) begin
            if (PC !== 5'(n) || INSTRUCCION !== prog[5'(n)]) bad++;
            n++;
         end
         if (FIN) fin_seen = 1'b1;
      end
      chk("clamp_count", 32'(n), 32'd32);
      chk("clamp_words_bad", 32'(bad), 32'd0);
      chk("clamp_fin_seen", 32'(fin_seen), 32'd1);
      tick();

      // Writes and restarts during a sequence are ignored.
      LONGITUD = 6'd3;
      BUCLE = 1'b0;
      LISTO = 1'b1;
      INICIO = 1'b1;
      tick();
      LONGITUD = 6'd1;
      CARGA_WE = 1'b1;
      CARGA_DIR = 5'd1;
      CARGA_DATO = 20'hFFFFF;
      tick();
      word("busy_w0", 20'h80000, 5'd0);
      tick();
      word("busy_w1", 20'h40421, 5'd1);
      tick();
      word("busy_w2", 20'h0A5E3, 5'd2);
      INICIO = 1'b0;
      CARGA_WE = 1'b0;
      tick();
      chk("busy_fin", 32'(FIN), 32'd1);
      tick();

      // Asynchronous reset in the middle of playback, then replay.
      LONGITUD = 6'd3;
      LISTO = 1'b1;
      INICIO = 1'b1;
      tick();
      INICIO = 1'b0;
      tick();
      tick();
      word("prerst_w1", 20'h40421, 5'd1);
      #1;
      RST_N = 1'b0;
      #1;
      chk("arst_valido", 32'(VALIDO), 32'd0);
      chk("arst_ocupado", 32'(OCUPADO), 32'd0);
      chk("arst_pc", 32'(PC), 32'd0);
      #1;
      RST_N = 1'b1;
      tick();
      run_basic("replay");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/secuenciador_instrucciones.md
Name: secuenciador_instrucciones

Overview:
- Issuing end of the 20-bit instruction interface: stores a short program and delivers it, one instruction word at a time, to the datapath consumer.
- Instruction field layout is fixed: [19] bank-A write enable, [18] memory-B write enable, [17:13] read address 1, [12:10] ALU select, [9:5] read address 2, [4:0] destination address.
- Program is loaded through a write port while idle, then played out once or in a loop under a valid/ready handshake.

Parameters:
- PROF, 32, program depth in words (power of two, 2..32)
- AW, 5, address width, equal to log2(PROF)
- IW, 20, instruction width; fixed at 20, do not override

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- CARGA_WE  input  1  program write strobe
- CARGA_DIR  input  AW  program write address
- CARGA_DATO  input  IW  program write data
- LONGITUD  input  AW+1  number of instructions to play, sampled on INICIO
- BUCLE  input  1  wrap to address 0 after the last word, sampled on INICIO
- INICIO  input  1  start pulse
- DETENER  input  1  stop request
- INSTRUCCION  output  IW  current instruction word
- VALIDO  output  1  INSTRUCCION is valid
- LISTO  input  1  consumer accepts the word
- OCUPADO  output  1  a sequence is active
- FIN  output  1  one-cycle pulse when a sequence ends
- PC  output  AW  address of the word currently presented

Behaviour:
- Interface: one clock CLK; reset RST_N is asynchronous and active-low.
- Reset:
  - All outputs are 0 and the state is REPOSO; VALIDO drops immediately on RST_N low, including mid-sequence.
  - Program memory contents are not reset.
- Program memory:
  - PROF x IW storage with a synchronous, one-cycle read.
  - A CARGA_WE write is accepted only in REPOSO and is ignored whenever OCUPADO=1.
- States:
  - REPOSO: waits for INICIO.
    - INICIO with LONGITUD=0 -> FIN.
    - INICIO with LONGITUD>0 -> LEER; latch LONGITUD (values above PROF are clamped to PROF) and BUCLE, set PC=0, issue read of address 0.
  - LEER: the read completes; next state is EMITIR with VALIDO=1 and INSTRUCCION=mem[0].
  - EMITIR: a transfer occurs when VALIDO=1 and LISTO=1.
    - On a transfer that is not the last word, PC increments and the next word is presented in the following cycle with VALIDO kept at 1. Sustained rate is one word per cycle while LISTO=1; the read address is muxed to PC+1 on a transfer.
    - On a transfer of the last word (PC = latched length - 1): if BUCLE=1, PC wraps to 0 and playback continues with no bubble; if BUCLE=0, next state is FIN.
  - FIN: FIN=1 and VALIDO=0 for one cycle, then REPOSO.
- Handshake rules:
  - While VALIDO=1 and LISTO=0, INSTRUCCION and PC hold stable.
  - VALIDO never drops without a transfer, except on reset.
- Latency: first word is valid 2 cycles after the INICIO cycle.
- DETENER:
  - In EMITIR: the word already presented still completes its handshake, then the block goes to FIN; no further word is issued.
  - In LEER: the block goes to FIN with no word issued.
- Other rules:
  - INICIO while OCUPADO=1 is ignored.
  - OCUPADO=1 in LEER and EMITIR, 0 in REPOSO and FIN.
  - PC is 0 whenever VALIDO=0.

Optional Feature:
- Macro SECUENCIADOR_PASO_EN.
- Defined: adds input PASO (1 bit), single-step mode. After each transfer, VALIDO stays 0 until a PASO pulse arrives; the next word becomes valid 1 cycle after the PASO cycle. PASO in any other state is ignored. The first word of a sequence also waits for PASO.
- Undefined: no PASO port; behaviour as described above.

Test Plan:
- Load mem[0..2] = 20'h80000, 20'h40421, 20'h0A5E3; LONGITUD=3, BUCLE=0, INICIO, LISTO=1 throughout -> VALIDO high on cycles 2, 3, 4 with those words in order and PC=0, 1, 2; FIN pulse on cycle 5; OCUPADO low from cycle 5.
- Same program with LISTO held 0 for 4 cycles while word 1 is presented -> INSTRUCCION=20'h40421 and PC=1 stay stable; sequence resumes with no lost or duplicated word.
- LONGITUD=2, BUCLE=1, LISTO=1 -> words run 0, 1, 0, 1, ... with no bubble; DETENER asserted while PC=1 -> word 1 transfers, then FIN, VALIDO=0.
- LONGITUD=0 with INICIO -> FIN on the next cycle, VALIDO never high; LONGITUD=40 -> clamped, 32 words issued.
- CARGA_WE mid-sequence to address 1 -> memory unchanged, word 1 played as originally loaded; INICIO mid-sequence ignored.
- RST_N pulled low while VALIDO=1 -> VALIDO, OCUPADO and PC are 0 asynchronously; after release the previous program replays correctly on INICIO.
